fifo_rd_stream: RTL and testbench

Read-side adapter that sits directly downstream of the async FIFO in the read clock domain. It converts the FIFO's rempty/rinc/rdata read interface into a registered valid/ready stream through a 2-entry skid buffer. This gives full throughput with no combinational path from m_ready to rinc. It also provides a synchronous flush.

---
 rtl/fifo_rd_stream.sv | 111 +++++++++++
 tb/tb_fifo_rd_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side stream adapter for the async FIFO: 2-entry skid buffer turning rempty/rinc/rdata into valid/ready.
// Optional accepted-transfer counter (xfer_cnt, CNT_W) enabled by defining RD_STREAM_CNT_EN.
module fifo_rd_stream #(
  parameter int DSIZE = 8
`ifdef RD_STREAM_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       level
`ifdef RD_STREAM_CNT_EN
  , output logic [CNT_W-1:0] xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [DSIZE-1:0] buf0_reg, buf0_next;
  logic [DSIZE-1:0] buf1_reg, buf1_next;
  logic             push;
  logic             pop;

  assign push = rinc;
  assign pop  = m_valid && m_ready;

  // State register: occupancy is the state.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_reg <= S0;
      buf0_reg  <= '0;
      buf1_reg  <= '0;
    end else begin
      state_reg <= state_next;
      buf0_reg  <= buf0_next;
      buf1_reg  <= buf1_next;
    end
  end

  // Next-state logic; flush wins but a same-cycle pop has already completed on the stream side.
  always_comb begin
    state_next = state_reg;
    buf0_next  = buf0_reg;
    buf1_next  = buf1_reg;
    if (flush) begin
      state_next = S0;
    end else begin
      case (state_reg)
        S0: begin
          if (push) begin
            buf0_next  = rdata;
            state_next = S1;
          end
        end
        S1: begin
          if (push && pop) begin
            buf0_next = rdata;
          end else if (push) begin
            buf1_next  = rdata;
            state_next = S2;
          end else if (pop) begin
            state_next = S0;
          end
        end
        S2: begin
          if (pop) begin
            buf0_next  = buf1_reg;
            state_next = S1;
          end
        end
        default: state_next = S0;
      endcase
    end
  end

  // Outputs: rinc never looks at m_ready, so no ready-to-pop combinational path exists.
  always_comb begin
    rinc    = !rempty && (state_reg != S2) && !flush && !rrst;
    m_valid = (state_reg != S0);
    m_data  = buf0_reg;
    level   = state_reg;
  end

`ifdef RD_STREAM_CNT_EN
  logic [CNT_W-1:0] cnt_reg;

  // Counts every handshake, including one in a flush cycle; only reset clears it.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      cnt_reg <= '0;
    end else if (pop) begin
      cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign xfer_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO model plus expected-word scoreboard.
// Define RD_STREAM_CNT_EN to also exercise the transfer counter (built with CNT_W=4).
module tb_fifo_rd_stream;

  localparam int DSIZE = 8;

  logic             rclk = 1'b0;
  logic             rrst;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             flush;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [1:0]       level;
`ifdef RD_STREAM_CNT_EN
  logic [3:0]       xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int rinc_pulses = 0;
  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_q[$];
  logic hold_empty = 1'b0;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(
    .DSIZE(DSIZE)
`ifdef RD_STREAM_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .flush   (flush),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .level   (level)
`ifdef RD_STREAM_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    rempty = hold_empty || (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic load(input logic [DSIZE-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    drive();
  endtask

  // One clock: sample at negedge+1, apply the edge to the models, re-drive, return at next negedge.
  task automatic cycle();
    logic hs, r, f;
    int n;
    #1;
    hs = m_valid && m_ready;
    r  = rinc;
    f  = flush;
    if (hs) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow observed=%0h expected=none", m_data);
      end else begin
        chk("sb_data", 32'(m_data), 32'(exp_q[0]));
      end
    end
    @(posedge rclk);
    if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
    if (r) begin
      rinc_pulses++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (f) begin
      n = exp_q.size() - fifo_q.size();
      repeat (n) void'(exp_q.pop_front());
    end
    #1 drive();
    @(negedge rclk);
  endtask

  initial begin
    rrst = 1'b1;
    flush = 1'b0;
    m_ready = 1'b0;
    drive();
    repeat (2) @(negedge rclk);

    // Reset state, with a word waiting at the FIFO head
    load(8'hAA);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_rinc", 32'(rinc), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    drive();
    @(negedge rclk);
    rrst = 1'b0;
    @(negedge rclk);

    // Stream mode
    m_ready = 1'b1;
    load(8'h11); load(8'h22); load(8'h33);
    #1;
    chk("stream_pre_valid", 32'(m_valid), 32'd0);
    chk("stream_pre_rinc", 32'(rinc), 32'd1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk("stream_valid", 32'(m_valid), 32'd1);
      chk("stream_level", 32'(level), 32'd1);
      cycle();
    end
    chk("stream_end_valid", 32'(m_valid), 32'd0);
    chk("stream_end_level", 32'(level), 32'd0);
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // Fill and stall
    m_ready = 1'b0;
    rinc_pulses = 0;
    for (int i = 1; i <= 5; i++) load(8'(i));
    repeat (4) cycle();
    #1;
    chk("stall_pulses", 32'(rinc_pulses), 32'd2);
    chk("stall_level", 32'(level), 32'd2);
    chk("stall_data", 32'(m_data), 32'h01);
    chk("stall_fifo_left", 32'(fifo_q.size()), 32'd3);
    chk("stall_rinc", 32'(rinc), 32'd0);

    // Release from full: five words, no gaps
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("release_valid", 32'(m_valid), 32'd1);
      cycle();
    end
    chk("release_level", 32'(level), 32'd0);
    chk("release_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush from S2 holding 0x01,0x02
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) load(8'(i));
    repeat (3) cycle();
    chk("flush_pre_level", 32'(level), 32'd2);
    flush = 1'b1;
    #1;
    chk("flush_rinc", 32'(rinc), 32'd0);
    cycle();
    flush = 1'b0;
    #1;
    chk("flush_valid", 32'(m_valid), 32'd0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_post_rinc", 32'(rinc), 32'd1);
    cycle();
    chk("flush_next_valid", 32'(m_valid), 32'd1);
    chk("flush_next_data", 32'(m_data), 32'h03);
    m_ready = 1'b1;
    repeat (3) cycle();
    chk("flush_drain_sb", 32'(exp_q.size()), 32'd0);
    chk("flush_drain_level", 32'(level), 32'd0);

    // rempty toggling every cycle: one pop per low cycle
    rinc_pulses = 0;
    for (int i = 0; i < 4; i++) load(8'hA0 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      hold_empty = (i % 2 == 1);
      drive();
      #1;
      chk("toggle_rinc", 32'(rinc), 32'(!hold_empty));
      cycle();
    end
    hold_empty = 1'b0;
    drive();
    repeat (2) cycle();
    chk("toggle_pulses", 32'(rinc_pulses), 32'd4);
    chk("toggle_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between clock edges
    for (int i = 0; i < 4; i++) load(8'hB0 + 8'(i));
    repeat (2) cycle();
    chk("arst_pre_valid", 32'(m_valid), 32'd1);
    #2 rrst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_data", 32'(m_data), 32'd0);
    chk("arst_rinc", 32'(rinc), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    drive();
    @(negedge rclk);
    rrst = 1'b0;
    @(negedge rclk);

`ifdef RD_STREAM_CNT_EN
    // Counter: 18 transfers wrap a 4-bit count to 2; a flush-cycle pop still counts
    chk("cnt_reset", 32'(xfer_cnt), 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) load(8'hC0 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    chk("cnt_drain_sb", 32'(exp_q.size()), 32'd0);
    chk("cnt_wrap", 32'(xfer_cnt), 32'd2);
    m_ready = 1'b0;
    load(8'hE1); load(8'hE2);
    repeat (3) cycle();
    chk("cnt_full_level", 32'(level), 32'd2);
    m_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    m_ready = 1'b0;
    chk("cnt_flush_pop", 32'(xfer_cnt), 32'd3);
    chk("cnt_flush_valid", 32'(m_valid), 32'd0);
`endif

    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
